// File: rtl/avalon_pio_in_debounce_pkg.sv
// Shared register offsets and bus width for the debounced PIO input slave.
package pio_in_pkg;

   localparam int         PIO_DATA_W      = 32;
   localparam logic [1:0] PIO_DATA_OFS    = 2'd0;
   localparam logic [1:0] PIO_IRQMASK_OFS = 2'd1;
   localparam logic [1:0] PIO_EDGECAP_OFS = 2'd2;
   localparam logic [1:0] PIO_RAW_OFS     = 2'd3;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchronizer, saturating stability counter and
// accepted level, with single-cycle rise/fall pulses when a new level is taken.
module pio_debounce_bit #(
   parameter int   DEBOUNCE_CYCLES = 250000,
   parameter int   CNT_W           = 18,
   parameter logic RST_VAL         = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic sync,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta;
   logic [CNT_W-1:0] count;
   logic             accept;

   assign accept = (sync != stable) && (count == CNT_TC);
   assign rise   = accept &  sync;
   assign fall   = accept & ~sync;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta   <= RST_VAL;
         sync   <= RST_VAL;
         stable <= RST_VAL;
         count  <= '0;
      end else begin
         meta <= pin;
         sync <= meta;
         // Any return to the accepted level restarts the stability window.
         if (sync == stable) begin
            count <= '0;
         end else if (count == CNT_TC) begin
            stable <= sync;
            count  <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/avalon_pio_in_debounce.sv
// Avalon-MM debounced PIO input with sticky edge capture and maskable irq.
// Define PIO_IN_FALLING_EDGE_EN to capture only 1->0 transitions of the debounced level.
module avalon_pio_in_debounce
   import pio_in_pkg::*;
#(
   parameter int               WIDTH           = 14,
   parameter int               DEBOUNCE_CYCLES = 250000,
   parameter int               CNT_W           = 18,
   parameter logic [WIDTH-1:0] RST_VAL         = 14'h000F
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            avs_address,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [PIO_DATA_W-1:0] avs_writedata,
   output logic [PIO_DATA_W-1:0] avs_readdata,
   output logic                  irq,
   input  logic [WIDTH-1:0]      pio_in
);

   logic [WIDTH-1:0]      sync_vec;
   logic [WIDTH-1:0]      stable_vec;
   logic [WIDTH-1:0]      rise_vec;
   logic [WIDTH-1:0]      fall_vec;
   logic [WIDTH-1:0]      edge_ev;
   logic [WIDTH-1:0]      irqmask;
   logic [WIDTH-1:0]      edgecap;
   logic [WIDTH-1:0]      w1c;
   logic [PIO_DATA_W-1:0] rd_mux;
   logic                  wdata_unused;

   assign wdata_unused = ^avs_writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W),
         .RST_VAL        (RST_VAL[i])
      ) u_bit (
         .clk    (clk),
         .reset_n(reset_n),
         .pin    (pio_in[i]),
         .sync   (sync_vec[i]),
         .stable (stable_vec[i]),
         .rise   (rise_vec[i]),
         .fall   (fall_vec[i])
      );
   end

`ifdef PIO_IN_FALLING_EDGE_EN
   assign edge_ev = fall_vec;
`else
   assign edge_ev = rise_vec | fall_vec;
`endif

   assign w1c = (avs_write && avs_address == PIO_EDGECAP_OFS)
                ? avs_writedata[WIDTH-1:0] : '0;

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         PIO_DATA_OFS:    rd_mux[WIDTH-1:0] = stable_vec;
         PIO_IRQMASK_OFS: rd_mux[WIDTH-1:0] = irqmask;
         PIO_EDGECAP_OFS: rd_mux[WIDTH-1:0] = edgecap;
         default:         rd_mux[WIDTH-1:0] = sync_vec;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irqmask      <= '0;
         edgecap      <= '0;
         irq          <= 1'b0;
         avs_readdata <= '0;
      end else begin
         // OR-ing the event in after the clear lets a coincident edge survive.
         edgecap <= (edgecap & ~w1c) | edge_ev;
         if (avs_write && avs_address == PIO_IRQMASK_OFS)
            irqmask <= avs_writedata[WIDTH-1:0];
         irq <= |(edgecap & irqmask);
         if (avs_read)
            avs_readdata <= rd_mux;
      end
   end

endmodule
